// File: rtl/comm_cmd_parser.sv
// Command framer: turns a UART RX byte stream (cmd, 4 addr, [4 data], CR, LF)
// into single read/write requests for the bus master, flagging bad or stalled frames.
module comm_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic              err_pulse,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CR,
        S_LF,
        S_ISSUE
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ERR_CMD   = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_TIME  = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               accept;
    logic               timed;

    assign rx_ready  = (state_q != S_ISSUE);
    assign req_valid = (state_q == S_ISSUE);
    assign accept    = rx_valid && rx_ready;
    assign timed     = (state_q == S_ADDR) || (state_q == S_DATA) ||
                       (state_q == S_CR)   || (state_q == S_LF);

    assign req_write = write_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign err_code  = err_code_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        err_pulse  = 1'b0;

        if (timed) begin
            if (accept) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (rx_data == 8'h72 || rx_data == 8'h52 ||
                        rx_data == 8'h77 || rx_data == 8'h57) begin
                        write_d = (rx_data == 8'h77) || (rx_data == 8'h57);
                        addr_d  = '0;
                        wdata_d = '0;
                        idx_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        err_pulse  = 1'b1;
                        err_code_d = ERR_CMD;
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = write_q ? S_DATA : S_CR;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_CR;
                    end
                end
            end
            S_CR: begin
                if (accept) begin
                    if (rx_data == 8'h0D) begin
                        state_d = S_LF;
                    end else begin
                        state_d    = S_IDLE;
                        err_pulse  = 1'b1;
                        err_code_d = ERR_FRAME;
                    end
                end
            end
            S_LF: begin
                if (accept) begin
                    if (rx_data == 8'h0A) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d    = S_IDLE;
                        err_pulse  = 1'b1;
                        err_code_d = ERR_FRAME;
                    end
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accepted byte in the expiry cycle takes priority over the timeout.
        if (TIMEOUT_CYCLES > 0 && timed && !accept && cnt_q == CNT_LAST) begin
            state_d    = S_IDLE;
            err_pulse  = 1'b1;
            err_code_d = ERR_TIME;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
        end
    end

endmodule
